gemm_result_collector: RTL and testbench

- Sits downstream of the inner-product unit and owns the issue-side handshake for its operand stream.
- Tracks in-flight dot products through the fixed, unstallable IPU pipeline with a valid delay line.
- Accumulates K_TILES partial sums per output element and packs COLS elements into one output row.
- Buffers rows in a small FIFO drained by a valid/ready consumer; credit-based flow control throttles issue so no IPU result is ever dropped.

---
 rtl/gemm_pkg.sv | 16 +
 rtl/gemm_result_collector_fifo.sv | 39 +++
 rtl/gemm_result_collector.sv | 97 +++++++++
 tb/tb_gemm_result_collector.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared types and constants for the GEMM result collector.
package gemm_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int LATENCY        = 5;
  localparam int K_TILES        = 4;
  localparam int COLS           = 8;
  localparam int FIFO_DEPTH     = 4;
  localparam int ISSUES_PER_ROW = COLS * K_TILES;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef data_t [COLS-1:0]      row_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gemm_result_collector_fifo.sv
// Synchronous row FIFO; pointers carry an extra wrap bit to tell full from empty.
module result_row_fifo
  import gemm_pkg::*;
#(
  parameter int W     = $bits(row_t),
  parameter int DEPTH = gemm_pkg::FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = clog2_min1(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/gemm_result_collector.sv
// Collects IPU dot products: K_TILES-deep accumulation per element, COLS elements per row,
// rows buffered in a FIFO with credit-throttled issue so no in-flight result is lost.
module gemm_result_collector
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH = gemm_pkg::DATA_WIDTH,
  parameter int LATENCY    = gemm_pkg::LATENCY,
  parameter int K_TILES    = gemm_pkg::K_TILES,
  parameter int COLS       = gemm_pkg::COLS,
  parameter int FIFO_DEPTH = gemm_pkg::FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [DATA_WIDTH-1:0]      ipu_data_in,
  output logic                       row_valid,
  input  logic                       row_ready,
  output logic [COLS*DATA_WIDTH-1:0] row_data
);
  localparam int ROW_ISSUES = COLS * K_TILES;
  localparam int IW  = clog2_min1(ROW_ISSUES);
  localparam int KW  = clog2_min1(K_TILES);
  localparam int CW  = clog2_min1(COLS);
  localparam int CRW = $clog2(FIFO_DEPTH + 1);

  typedef logic [DATA_WIDTH-1:0] elem_t;
  typedef elem_t [COLS-1:0]      rowbuf_t;

  logic [LATENCY-1:0] vld_pipe;
  logic [IW-1:0]      issue_cnt;
  logic [CRW-1:0]     credits;
  logic [KW-1:0]      k;
  logic [CW-1:0]      col;
  elem_t              acc, elem;
  rowbuf_t            rowbuf, row_push;
  logic               fire, reserve, tail, elem_done, push, pop, full, empty;

  // A row's FIFO slot is reserved when its first operand issues, so every
  // result already in the IPU pipe is guaranteed somewhere to land.
  assign issue_ready = !rst && (credits != '0 || issue_cnt != '0);
  assign fire        = issue_valid && issue_ready;
  assign reserve     = fire && (issue_cnt == '0);
  assign tail        = vld_pipe[LATENCY-1];
  assign elem        = (k == '0) ? ipu_data_in : acc + ipu_data_in;
  assign elem_done   = tail && (k == KW'(K_TILES-1));
  assign push        = elem_done && (col == CW'(COLS-1));
  assign row_valid   = !empty;
  assign pop         = row_valid && row_ready;

  always_comb begin
    row_push      = rowbuf;
    row_push[col] = elem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      issue_cnt <= '0;
      credits   <= CRW'(FIFO_DEPTH);
      k         <= '0;
      col       <= '0;
      acc       <= '0;
      rowbuf    <= '0;
    end else begin
      vld_pipe <= LATENCY'({vld_pipe, fire});
      if (fire) issue_cnt <= (issue_cnt == IW'(ROW_ISSUES-1)) ? '0 : issue_cnt + 1'b1;
      if (reserve && !pop)      credits <= credits - 1'b1;
      else if (pop && !reserve) credits <= credits + 1'b1;
      if (tail) begin
        acc <= elem;
        if (elem_done) begin
          rowbuf[col] <= elem;
          k           <= '0;
          col         <= (col == CW'(COLS-1)) ? '0 : col + 1'b1;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && full));
  end

  result_row_fifo #(.W(COLS*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (row_push),
    .full  (full),
    .empty (empty),
    .head  (row_data)
  );
endmodule

// File: tb/tb_gemm_result_collector.sv
// Scoreboard bench: a behavioural IPU pipe feeds the collector, expected rows are queued at issue time.
module tb_gemm_result_collector;
  localparam int DW = 32, LAT = 5, KT = 4, NC = 8, FD = 4, NI = KT * NC, RW = NC * DW;

  logic          clk = 0, rst = 1, issue_valid = 0, issue_ready, row_valid, row_ready;
  logic          rnd_ready = 0, ready_force = 0, rnd_bit = 0;
  logic [DW-1:0] ipu_data_in, cur_val = '0;
  logic [RW-1:0] row_data;
  logic [DW-1:0] pipe [LAT];
  logic [DW-1:0] rv [NI];
  logic [RW-1:0] exp_q [$];
  logic [RW-1:0] got [64];
  int            got_cyc [64];
  int            got_n = 0, cyc = 0, last_fire = 0, rd = 0, n_chk = 0, n_pass = 0;

  gemm_result_collector #(.DATA_WIDTH(DW), .LATENCY(LAT), .K_TILES(KT), .COLS(NC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .ipu_data_in(ipu_data_in), .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rnd_bit <= 1'($urandom_range(0, 1));
  end
  assign row_ready = rnd_ready ? rnd_bit : ready_force;

  // IPU stand-in: fixed LATENCY pipe, emits 0xDEAD when nothing was issued
  always @(posedge clk) begin
    pipe[0] <= (issue_valid && issue_ready) ? cur_val : 32'hDEAD;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ipu_data_in = pipe[LAT-1];

  always @(negedge clk) begin
    if (!rst && row_valid && row_ready && got_n < 64) begin
      got[got_n]     <= row_data;
      got_cyc[got_n] <= cyc;
      got_n          <= got_n + 1;
    end
  end

  function automatic logic [RW-1:0] row_model();
    logic [RW-1:0] r = '0;
    logic [DW-1:0] s;
    for (int c = 0; c < NC; c++) begin
      s = '0;
      for (int kk = 0; kk < KT; kk++) s = s + rv[c*KT + kk];
      r[c*DW +: DW] = s;
    end
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic issue_one(input logic [DW-1:0] v, input int gap, output bit ok);
    ok = 0;
    while (gap > 0 && int'($urandom_range(0, 99)) < gap) begin
      issue_valid = 0;
      cycle();
    end
    issue_valid = 1;
    cur_val     = v;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (issue_ready) begin
        ok        = 1;
        last_fire = cyc;
      end
      cycle();
      if (ok) break;
    end
    issue_valid = 0;
  endtask

  task automatic send_row(input int first, input int gap);
    bit ok;
    exp_q.push_back(row_model());
    for (int i = first; i < NI; i++) begin
      issue_one(rv[i], gap, ok);
      if (!ok) begin
        n_chk++;
        $display("FAIL issue_timeout: issue %0d not accepted, issue_ready=%b required 1", i, issue_ready);
        return;
      end
    end
  endtask

  task automatic wait_rows(input int n, input int budget, output bit ok);
    ok = 0;
    for (int t = 0; t < budget; t++) begin
      if (got_n >= n) begin
        ok = 1;
        break;
      end
      cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1;
    cycle();
    @(negedge clk);
    n_chk++;
    if (issue_ready !== 1'b0 || row_valid !== 1'b0 || row_data !== '0)
      $display("FAIL reset_state: ready=%b valid=%b data=%h required 0 0 0", issue_ready, row_valid, row_data);
    else n_pass++;
    cycle();
    rst = 0;
    @(negedge clk);
    n_chk++;
    if (issue_ready !== 1'b1) $display("FAIL reset_release: issue_ready=%b required 1", issue_ready);
    else n_pass++;
    n_chk++;
    if (row_valid !== 1'b0) $display("FAIL reset_row_valid: row_valid=%b required 0", row_valid);
    else n_pass++;
    cycle();
  endtask

  task automatic test_single_row();
    bit ok;
    logic [RW-1:0] e;
    ready_force = 1;
    for (int i = 0; i < NI; i++) rv[i] = 32'd1;
    send_row(0, 0);
    wait_rows(rd + 1, 100, ok);
    n_chk++;
    if (!ok || got_cyc[rd] !== last_fire + LAT + 1)
      $display("FAIL single_latency: row seen at cycle %0d, required %0d", got_cyc[rd], last_fire + LAT + 1);
    else n_pass++;
    while (exp_q.size() > 0) begin
      wait_rows(rd + 1, 200, ok);
      e = exp_q.pop_front();
      n_chk++;
      if (!ok) $display("FAIL single_wait: rows %0d required %0d", got_n, rd + 1);
      else if (got[rd] !== e) $display("FAIL single_data: got %h required %h", got[rd], e);
      else n_pass++;
      rd++;
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [RW-1:0] e;
    for (int i = 0; i < NI; i++) rv[i] = '0;
    rv[0] = 32'hFFFF_FFFF;
    rv[1] = 32'd2;
    send_row(0, 0);
    while (exp_q.size() > 0) begin
      wait_rows(rd + 1, 200, ok);
      e = exp_q.pop_front();
      n_chk++;
      if (!ok) $display("FAIL wrap_wait: rows %0d required %0d", got_n, rd + 1);
      else if (got[rd] !== e) $display("FAIL wrap_data: got %h required %h", got[rd], e);
      else n_pass++;
      rd++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [RW-1:0] e;
    ready_force = 0;
    for (int r = 0; r < FD; r++) begin
      for (int i = 0; i < NI; i++) rv[i] = DW'(r + 1);
      send_row(0, 0);
    end
    issue_valid = 1;
    cur_val     = 32'h55;
    @(negedge clk);
    n_chk++;
    if (issue_ready !== 1'b0) $display("FAIL bp_extra_issue: issue_ready=%b required 0", issue_ready);
    else n_pass++;
    repeat (10) cycle();
    @(negedge clk);
    n_chk++;
    if (issue_ready !== 1'b0 || row_valid !== 1'b1 || got_n !== rd)
      $display("FAIL bp_stall: ready=%b valid=%b rows=%0d required 0 1 %0d", issue_ready, row_valid, got_n, rd);
    else n_pass++;
    cycle();
    ready_force = 1;
    @(negedge clk);
    n_chk++;
    if (issue_ready !== 1'b0) $display("FAIL bp_pop_cycle: issue_ready=%b required 0", issue_ready);
    else n_pass++;
    cycle();
    ready_force = 0;
    issue_valid = 0;
    @(negedge clk);
    n_chk++;
    if (issue_ready !== 1'b1) $display("FAIL bp_after_pop: issue_ready=%b required 1", issue_ready);
    else n_pass++;
    // reservation and pop in the same cycle with one credit free
    for (int i = 0; i < NI; i++) rv[i] = 32'd5;
    cycle();
    issue_valid = 1;
    cur_val     = rv[0];
    ready_force = 1;
    @(negedge clk);
    n_chk++;
    if (issue_ready !== 1'b1 || row_valid !== 1'b1)
      $display("FAIL simul_fire: ready=%b valid=%b required 1 1", issue_ready, row_valid);
    else n_pass++;
    cycle();
    issue_valid = 0;
    ready_force = 0;
    send_row(1, 0);
    @(negedge clk);
    n_chk++;
    if (issue_ready !== 1'b1) $display("FAIL simul_credit_kept: issue_ready=%b required 1", issue_ready);
    else n_pass++;
    cycle();
    for (int i = 0; i < NI; i++) rv[i] = 32'd6;
    send_row(0, 0);
    @(negedge clk);
    n_chk++;
    if (issue_ready !== 1'b0) $display("FAIL credits_zero: issue_ready=%b required 0", issue_ready);
    else n_pass++;
    // credits at zero: the pop cycle keeps ready low, the next cycle reserves and pops together
    for (int i = 0; i < NI; i++) rv[i] = 32'd7;
    cycle();
    issue_valid = 1;
    cur_val     = rv[0];
    ready_force = 1;
    @(negedge clk);
    n_chk++;
    if (issue_ready !== 1'b0) $display("FAIL zero_pop_cycle: issue_ready=%b required 0", issue_ready);
    else n_pass++;
    cycle();
    @(negedge clk);
    n_chk++;
    if (issue_ready !== 1'b1) $display("FAIL zero_next_cycle: issue_ready=%b required 1", issue_ready);
    else n_pass++;
    cycle();
    issue_valid = 0;
    ready_force = 0;
    send_row(1, 0);
    @(negedge clk);
    n_chk++;
    if (issue_ready !== 1'b1) $display("FAIL zero_credit_kept: issue_ready=%b required 1", issue_ready);
    else n_pass++;
    cycle();
    ready_force = 1;
    while (exp_q.size() > 0) begin
      wait_rows(rd + 1, 300, ok);
      e = exp_q.pop_front();
      n_chk++;
      if (!ok) $display("FAIL bp_wait: rows %0d required %0d", got_n, rd + 1);
      else if (got[rd] !== e) $display("FAIL bp_order: row %0d got %h required %h", rd, got[rd], e);
      else n_pass++;
      rd++;
    end
    repeat (5) cycle();
    @(negedge clk);
    n_chk++;
    if (row_valid !== 1'b0 || got_n !== rd || int'(dut.credits) != FD)
      $display("FAIL bp_drained: valid=%b rows=%0d credits=%0d required 0 %0d %0d",
               row_valid, got_n, dut.credits, rd, FD);
    else n_pass++;
    cycle();
  endtask

  task automatic test_reset_mid_row();
    bit ok;
    logic [RW-1:0] e;
    for (int i = 0; i < NI; i++) rv[i] = 32'd9;
    for (int i = 0; i < 10; i++) begin
      issue_one(rv[i], 0, ok);
      if (!ok) begin
        n_chk++;
        $display("FAIL rst_issue: issue %0d not accepted, required accepted", i);
      end
    end
    rst = 1;
    @(negedge clk);
    n_chk++;
    if (issue_ready !== 1'b0) $display("FAIL rst_ready_low: issue_ready=%b required 0", issue_ready);
    else n_pass++;
    cycle();
    rst = 0;
    @(negedge clk);
    n_chk++;
    if (issue_ready !== 1'b1) $display("FAIL rst_ready_high: issue_ready=%b required 1", issue_ready);
    else n_pass++;
    repeat (12) cycle();
    @(negedge clk);
    n_chk++;
    if (row_valid !== 1'b0 || got_n !== rd)
      $display("FAIL rst_discard: valid=%b rows=%0d required 0 %0d", row_valid, got_n, rd);
    else n_pass++;
    cycle();
    for (int i = 0; i < NI; i++) rv[i] = 32'd3;
    send_row(0, 0);
    while (exp_q.size() > 0) begin
      wait_rows(rd + 1, 200, ok);
      e = exp_q.pop_front();
      n_chk++;
      if (!ok) $display("FAIL rst_row_wait: rows %0d required %0d", got_n, rd + 1);
      else if (got[rd] !== e) $display("FAIL rst_row_data: got %h required %h", got[rd], e);
      else n_pass++;
      rd++;
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [RW-1:0] e;
    rnd_ready = 1;
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NI; i++) rv[i] = $urandom();
      send_row(0, 30);
    end
    while (exp_q.size() > 0) begin
      wait_rows(rd + 1, 2000, ok);
      e = exp_q.pop_front();
      n_chk++;
      if (!ok) $display("FAIL rand_wait: rows %0d required %0d", got_n, rd + 1);
      else if (got[rd] !== e) $display("FAIL rand_data: row %0d got %h required %h", rd, got[rd], e);
      else n_pass++;
      rd++;
    end
    rnd_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_wrap();
    test_backpressure();
    test_reset_mid_row();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
